// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the handshaked ALU pipeline stage: opcode encoding,
// opcode width and the IDLE/BUSY control state encoding.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int OP_W = 4;

  // Codes 0..3 keep the legacy 2-bit ALU encoding so old decoders still map.
  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_W-1:0] OP_SLT  = 4'd5;
  localparam logic [OP_W-1:0] OP_SLTU = 4'd6;
  localparam logic [OP_W-1:0] OP_SLL  = 4'd7;
  localparam logic [OP_W-1:0] OP_SRL  = 4'd8;
  localparam logic [OP_W-1:0] OP_SRA  = 4'd9;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd10;

  // Control state: IDLE accepts work, BUSY while the iterative multiply runs.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// -----------------------------------------------------------------------------
// alu_mul_iter
// Iterative shift-add multiplier producing the low WIDTH bits of a*b.
// The first partial product is folded into the start edge, so the final step
// happens WIDTH-1 edges after start and 'done' is visible during the following
// cycle; a consumer registering p on 'done' therefore captures the product
// exactly WIDTH edges after start.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous abort (drops any multiply in progress)
//   start      : load operands and perform the first step
//   a, b       : multiplicand / multiplier
//   busy       : multiply in progress
//   done       : one-cycle pulse, p holds the final product
//   p          : product accumulator
// -----------------------------------------------------------------------------
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] addend_s;

  // Partial product selected by the current multiplier LSB.
  always_comb begin
    addend_s = {WIDTH{1'b0}};
    if (mplier_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = {WIDTH{1'b0}};
    end
  end

  // Shift-add datapath and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (clr) begin
      cnt_r  <= {CNT_W{1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      // Step 1 happens here: acc = b[0] ? a : 0.
      acc_r    <= b[0] ? a : {WIDTH{1'b0}};
      mcand_r  <= a << 1;
      mplier_r <= b >> 1;
      cnt_r    <= {{(CNT_W-1){1'b0}}, 1'b1};
      busy_r   <= 1'b1;
      done_r   <= 1'b0;
    end else if (busy_r) begin
      acc_r    <= acc_r + addend_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      if (cnt_r == CNT_W'(WIDTH - 1)) begin
        cnt_r  <= {CNT_W{1'b0}};
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign p    = acc_r;

endmodule

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Handshaked ALU stage between operand fetch and writeback. Single-cycle ops
// produce a registered result one edge after accept; MUL runs on the iterative
// multiplier and returns WIDTH edges after accept. One 1-deep output register,
// one operation in flight.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : synchronous abort of in-flight MUL and held result
//   in_valid / in_ready  : operand handshake
//   a, b, op             : operands and opcode (alu_pkg encoding)
//   out_valid / out_ready: result handshake
//   c, zero, ovf, err    : result and its registered status flags
// -----------------------------------------------------------------------------
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  localparam int SH_W = $clog2(WIDTH);

  alu_state_e       state_r;
  alu_state_e       state_nxt_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] c_r;
  logic             zero_r;
  logic             ovf_r;
  logic             err_r;

  logic             in_ready_s;
  logic             accept_s;
  logic             is_mul_s;
  logic             mul_start_s;
  logic             mul_busy_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_p_s;

  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [SH_W-1:0]  shamt_s;
  logic [WIDTH-1:0] res_c_s;
  logic             res_ovf_s;
  logic             res_err_s;

  // Signed overflow of a+b: operands agree in sign, result differs.
  function automatic logic add_ovf(input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y,
                                   input logic [WIDTH-1:0] r);
    return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  // Signed overflow of x-y: operands differ in sign, result sign leaves x's.
  function automatic logic sub_ovf(input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y,
                                   input logic [WIDTH-1:0] r);
    return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  assign sum_s   = a + b;
  assign diff_s  = a - b;
  assign shamt_s = b[SH_W-1:0];

  // rst_n is folded in so the producer sees in_ready low throughout reset.
  assign in_ready_s  = rst_n && !flush && (state_r == IDLE) && !mul_busy_s &&
                       (!out_valid_r || out_ready);
  assign accept_s    = in_valid && in_ready_s;
  assign is_mul_s    = (op == OP_MUL) && (MUL_EN == 1'b1);
  assign mul_start_s = accept_s && is_mul_s;

  // Single-cycle result and flag decode; MUL result comes from the multiplier.
  always_comb begin
    res_c_s   = {WIDTH{1'b0}};
    res_ovf_s = 1'b0;
    res_err_s = 1'b0;
    case (op)
      OP_ADD: begin
        res_c_s   = sum_s;
        res_ovf_s = add_ovf(a, b, sum_s);
      end
      OP_SUB: begin
        res_c_s   = diff_s;
        res_ovf_s = sub_ovf(a, b, diff_s);
      end
      OP_AND:  res_c_s = a & b;
      OP_OR:   res_c_s = a | b;
      OP_XOR:  res_c_s = a ^ b;
      OP_SLT:  res_c_s = ($signed(a) < $signed(b)) ? {{(WIDTH-1){1'b0}}, 1'b1}
                                                   : {WIDTH{1'b0}};
      OP_SLTU: res_c_s = (a < b) ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
      OP_SLL:  res_c_s = a << shamt_s;
      OP_SRL:  res_c_s = a >> shamt_s;
      OP_SRA:  res_c_s = $signed(a) >>> shamt_s;
      OP_MUL: begin
        if (MUL_EN == 1'b1) begin
          res_c_s = {WIDTH{1'b0}};
        end else begin
          res_err_s = 1'b1;
        end
      end
      default: res_err_s = 1'b1;
    endcase
  end

  // IDLE/BUSY next-state; flush always returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = mul_start_s ? BUSY : IDLE;
        BUSY:    state_nxt_s = mul_done_s ? IDLE : BUSY;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output register: MUL completion, new single-cycle result, drain, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      c_r         <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
      err_r       <= 1'b0;
    end else if (flush) begin
      // c and flags are deliberately kept; only the valid is dropped.
      out_valid_r <= 1'b0;
    end else if (mul_done_s && (state_r == BUSY)) begin
      out_valid_r <= 1'b1;
      c_r         <= mul_p_s;
      zero_r      <= (mul_p_s == {WIDTH{1'b0}});
      ovf_r       <= 1'b0;
      err_r       <= 1'b0;
    end else if (accept_s) begin
      if (is_mul_s) begin
        // Old result is being consumed this cycle; nothing valid until MUL ends.
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= 1'b1;
        c_r         <= res_c_s;
        zero_r      <= (res_c_s == {WIDTH{1'b0}});
        ovf_r       <= res_ovf_s;
        err_r       <= res_err_s;
      end
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .start (mul_start_s),
    .a     (a),
    .b     (b),
    .busy  (mul_busy_s),
    .done  (mul_done_s),
    .p     (mul_p_s)
  );

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign c         = c_r;
  assign zero      = zero_r;
  assign ovf       = ovf_r;
  assign err       = err_r;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
// Self-checking bench for alu_pipe: directed scenarios plus randomized traffic,
// all checked against a transaction-level reference model (plain arithmetic
// result function + valid/busy bookkeeping). Extra instances cover WIDTH=8 and
// MUL_EN=0.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush, in_valid, out_ready;
  logic [31:0] a, b;
  logic [3:0]  op;
  logic        in_ready, out_valid, zero, ovf, err;
  logic [31:0] c;

  logic        flush8, in_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [3:0]  op8;
  logic        in_ready8, out_valid8, zero8, ovf8, err8;
  logic [7:0]  c8;

  logic        in_ready_nm, out_valid_nm, zero_nm, ovf_nm, err_nm;
  logic [31:0] c_nm;

  alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .zero(zero), .ovf(ovf), .err(err));

  alu_pipe #(.WIDTH(8), .MUL_EN(1'b1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush8), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
    .c(c8), .zero(zero8), .ovf(ovf8), .err(err8));

  alu_pipe #(.WIDTH(32), .MUL_EN(1'b0)) u_dut_nm (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_nm),
    .a(a), .b(b), .op(op), .out_valid(out_valid_nm), .out_ready(out_ready),
    .c(c_nm), .zero(zero_nm), .ovf(ovf_nm), .err(err_nm));

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3;
  localparam logic [3:0] SLT = 4'd5, SLTU = 4'd6, SRA = 4'd9, MUL = 4'd10;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  bit          m_valid;
  logic [31:0] m_c;
  bit          m_z, m_o, m_e;
  int          m_mul_left;
  logic [31:0] m_mul_c;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Result of one operation, from the opcode definitions with wide arithmetic.
  function automatic void ref_alu(input logic [31:0] x, input logic [31:0] y,
                                  input logic [3:0] o, output logic [31:0] r,
                                  output bit rz, output bit ro, output bit re);
    longint sx, sy, s;
    logic [63:0] prod;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ro = 1'b0;
    re = 1'b0;
    r  = 32'd0;
    case (o)
      4'd0: begin s = sx + sy; r = x + y; ro = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd1: begin s = sx - sy; r = x - y; ro = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = (sx < sy) ? 32'd1 : 32'd0;
      4'd6: r = (x < y) ? 32'd1 : 32'd0;
      4'd7: r = x << y[4:0];
      4'd8: r = x >> y[4:0];
      4'd9: begin s = sx >>> y[4:0]; r = s[31:0]; end
      4'd10: begin prod = {32'd0, x} * {32'd0, y}; r = prod[31:0]; end
      default: begin re = 1'b1; r = 32'd0; end
    endcase
    rz = (r == 32'd0);
  endfunction

  // One clock of the main DUT: drive at negedge, check in_ready, advance the
  // model across the posedge, then check outputs at the following negedge.
  task automatic cycle(input bit v, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [3:0] iop, input bit ordy, input bit fl);
    bit exp_rdy;
    logic [31:0] rc;
    bit rz, ro, re;
    in_valid = v; a = ia; b = ib; op = iop; out_ready = ordy; flush = fl;
    #1;
    exp_rdy = !fl && (m_mul_left == 0) && (!m_valid || ordy);
    check_eq("in_ready", in_ready, exp_rdy);
    if (fl) begin
      m_valid = 0; m_mul_left = 0;
    end else if (m_mul_left > 0) begin
      m_mul_left--;
      if (m_mul_left == 0) begin
        m_valid = 1; m_c = m_mul_c; m_z = (m_mul_c == 32'd0); m_o = 0; m_e = 0;
      end
    end else if (v && exp_rdy) begin
      ref_alu(ia, ib, iop, rc, rz, ro, re);
      if (iop == MUL) begin
        m_valid = 0; m_mul_left = 32; m_mul_c = rc;
      end else begin
        m_valid = 1; m_c = rc; m_z = rz; m_o = ro; m_e = re;
      end
    end else if (m_valid && ordy) begin
      m_valid = 0;
    end
    @(negedge clk);
    check_eq("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check_eq("c", c, m_c);
      check_eq("zero", zero, m_z);
      check_eq("ovf", ovf, m_o);
      check_eq("err", err, m_e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 32'd0, ADD, 1'b1, 1'b0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom % 8)
      0: return 32'd0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom % 40);
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] rop;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 32'd0; b = 32'd0; op = 4'd0;
    flush8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = 8'd0; b8 = 8'd0; op8 = 4'd0;
    m_valid = 0; m_c = 32'd0; m_z = 0; m_o = 0; m_e = 0; m_mul_left = 0; m_mul_c = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_c", c, 32'd0);
    check_eq("rst_flags", {zero, ovf, err}, 3'b000);
    check_eq("rst_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Legacy ops back-to-back
    cycle(1'b1, 32'd7, 32'd9, ADD, 1'b1, 1'b0);
    check_eq("leg_add", {out_valid, c}, {1'b1, 32'd16});
    cycle(1'b1, 32'd7, 32'd9, SUB, 1'b1, 1'b0);
    check_eq("leg_sub", {out_valid, c}, {1'b1, 32'hFFFF_FFFE});
    cycle(1'b1, 32'd7, 32'd9, AND_, 1'b1, 1'b0);
    check_eq("leg_and", {out_valid, c}, {1'b1, 32'd1});
    cycle(1'b1, 32'd7, 32'd9, OR_, 1'b1, 1'b0);
    check_eq("leg_or", {out_valid, c}, {1'b1, 32'd15});

    // Flags and boundary ops
    cycle(1'b1, 32'h7FFF_FFFF, 32'd1, ADD, 1'b1, 1'b0);
    check_eq("add_ovf", {c, ovf}, {32'h8000_0000, 1'b1});
    cycle(1'b1, 32'd5, 32'd5, SUB, 1'b1, 1'b0);
    check_eq("sub_zero", zero, 1'b1);
    cycle(1'b1, 32'h8000_0000, 32'd4, SRA, 1'b1, 1'b0);
    check_eq("sra", c, 32'hF800_0000);
    cycle(1'b1, 32'hFFFF_FFFF, 32'd1, SLT, 1'b1, 1'b0);
    check_eq("slt", c, 32'd1);
    cycle(1'b1, 32'hFFFF_FFFF, 32'd1, SLTU, 1'b1, 1'b0);
    check_eq("sltu", c, 32'd0);
    cycle(1'b1, 32'd3, 32'd4, 4'd12, 1'b1, 1'b0);
    check_eq("illegal", {err, c}, {1'b1, 32'd0});

    // Reset in the middle of a MUL
    cycle(1'b1, 32'd3, 32'd5, MUL, 1'b1, 1'b0);
    idle(4);
    rst_n = 1'b0;
    #1;
    check_eq("rstmul_out_valid", out_valid, 1'b0);
    check_eq("rstmul_c", c, 32'd0);
    check_eq("rstmul_in_ready", in_ready, 1'b0);
    m_valid = 0; m_mul_left = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(40);

    // MUL latency (WIDTH=32)
    cycle(1'b1, 32'h0001_0001, 32'h0001_0001, MUL, 1'b1, 1'b0);
    n = 0;
    do begin
      cycle(1'b0, 32'd0, 32'd0, ADD, 1'b0, 1'b0);
      n++;
    end while (!out_valid && n < 40);
    check_eq("mul32_latency", n, 32);
    check_eq("mul32_c", c, 32'h0002_0001);
    idle(2);

    // MUL latency (WIDTH=8)
    a8 = 8'd15; b8 = 8'd17; op8 = MUL; in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    check_eq("mul8_in_ready_busy", in_ready8, 1'b0);
    n = 0;
    while (!out_valid8 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("mul8_latency", n, 8);
    check_eq("mul8_c", c8, 8'hFF);
    @(negedge clk);

    // Backpressure
    cycle(1'b1, 32'd1, 32'd2, ADD, 1'b0, 1'b0);
    check_eq("bp_first", {out_valid, c}, {1'b1, 32'd3});
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'd5, 32'd5, ADD, 1'b0, 1'b0);
      check_eq("bp_hold", {out_valid, c}, {1'b1, 32'd3});
    end
    cycle(1'b1, 32'd5, 32'd5, ADD, 1'b1, 1'b0);
    check_eq("bp_release", {out_valid, c}, {1'b1, 32'd10});

    // Flush during MUL busy
    idle(1);
    cycle(1'b1, 32'd3, 32'd5, MUL, 1'b1, 1'b0);
    idle(5);
    cycle(1'b0, 32'd0, 32'd0, ADD, 1'b1, 1'b1);
    check_eq("flush_mul_valid", out_valid, 1'b0);
    idle(40);

    // Flush with held result and a pending input
    cycle(1'b1, 32'd4, 32'd4, ADD, 1'b0, 1'b0);
    cycle(1'b1, 32'd9, 32'd9, ADD, 1'b1, 1'b1);
    check_eq("flush_held", {out_valid, c}, {1'b0, 32'd8});
    idle(1);

    // MUL_EN=0 decodes op 10 as illegal
    cycle(1'b1, 32'd6, 32'd7, MUL, 1'b1, 1'b0);
    check_eq("nomul_err", {out_valid_nm, err_nm, c_nm}, {1'b1, 1'b1, 32'd0});
    idle(34);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rop = 4'($urandom_range(0, 15));
      if (rop == MUL && ($urandom % 3) != 0) rop = ADD;
      cycle(($urandom % 10) < 7, rnd_operand(), rnd_operand(), rop,
            ($urandom % 4) != 0, ($urandom % 25) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
